// File: rtl/pipelined_shift_rotate_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_shift_rotate_if
// Description : Handshake bundle for the pipelined shift/rotate/funnel unit.
//               Input channel : in_valid/in_ready plus op, a, b, n, tag.
//               Output channel: out_valid/out_ready plus data, tag, err.
//               master = operand source / result sink side,
//               slave  = the shift/rotate unit itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_shift_rotate_if #(
    parameter int W  = 8,
    parameter int TW = 4
);
    localparam int AW = $clog2(W) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [AW-1:0] in_n;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_n, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_n, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_shift_rotate.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_shift_rotate
// Description : Pipelined shift/rotate/funnel unit. Every op is decoded into a
//               right funnel extract ({hi,lo} >> r)[W-1:0]; the shift is then
//               done as a log2 barrel across registered stages.
//               Latency is $clog2(W)+2 cycles; one op per cycle.
// Ports       : clk  - clock
//               nrst - asynchronous active-low reset
//               bus  - pipelined_shift_rotate_if.slave (in/out handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shift_rotate #(
    parameter int W  = 8,
    parameter int TW = 4
) (
    input  wire logic                 clk,
    input  wire logic                 nrst,
    pipelined_shift_rotate_if.slave   bus
);
    localparam int AW = $clog2(W) + 1;   // shift-amount width
    localparam int LW = AW - 1;          // log2(W)
    localparam logic [AW-1:0] W_A = AW'(W);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_FUN = 3'b101;

    // Stages 0..AW-1 carry the 2W-bit funnel word; the final stage only
    // needs the W-bit result, so it lives in dedicated out_* flops.
    logic [2*W-1:0] word_q [0:AW-1];
    logic [2*W-1:0] word_d [0:AW-1];
    logic [AW-1:0]  r_q    [0:AW-1];
    logic [AW-1:0]  r_d    [0:AW-1];
    logic [TW-1:0]  tag_q  [0:AW-1];
    logic [TW-1:0]  tag_d  [0:AW-1];
    logic           err_q  [0:AW-1];
    logic           err_d  [0:AW-1];
    logic           vld_q  [0:AW-1];
    logic           vld_d  [0:AW-1];

    logic [W-1:0]   out_data_q, out_data_d;
    logic [TW-1:0]  out_tag_q,  out_tag_d;
    logic           out_err_q,  out_err_d;
    logic           out_vld_q,  out_vld_d;

    logic           adv;

    // ------------------------------------------------------------------
    // Decode: map op/a/b/n onto hi, lo and right-shift amount r
    // ------------------------------------------------------------------
    logic [W-1:0]   dec_hi, dec_lo;
    logic [AW-1:0]  dec_r;
    logic           dec_err;
    logic           n_ge_w;
    logic [AW-1:0]  n_mod;
    logic [AW-1:0]  rol_t;

    always_comb begin
        n_ge_w  = bus.in_n[AW-1];
        n_mod   = {1'b0, bus.in_n[LW-1:0]};
        rol_t   = W_A - n_mod;          // low LW bits give (W - n mod W) mod W
        dec_hi  = '0;
        dec_lo  = '0;
        dec_r   = '0;
        dec_err = 1'b0;
        case (bus.in_op)
            OP_SLL: begin
                // n=0 yields r=W, which returns a unchanged from the upper half
                if (!n_ge_w) begin
                    dec_hi = bus.in_a;
                    dec_r  = W_A - bus.in_n;
                end
            end
            OP_SRL: begin
                dec_lo = bus.in_a;
                dec_r  = bus.in_n;      // r >= W naturally shifts a out entirely
            end
            OP_SRA: begin
                dec_hi = {W{bus.in_a[W-1]}};
                dec_lo = bus.in_a;
                dec_r  = n_ge_w ? W_A : bus.in_n;
            end
            OP_ROL: begin
                dec_hi = bus.in_a;
                dec_lo = bus.in_a;
                dec_r  = {1'b0, rol_t[LW-1:0]};
            end
            OP_ROR: begin
                dec_hi = bus.in_a;
                dec_lo = bus.in_a;
                dec_r  = n_mod;
            end
            OP_FUN: begin
                dec_hi = bus.in_a;
                dec_lo = bus.in_b;
                dec_r  = bus.in_n;
            end
            default: dec_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Barrel stages: stage k conditionally shifts by 2^(k-1)
    // ------------------------------------------------------------------
    logic [2*W-1:0] shifted [1:AW-1];

    generate
        for (genvar k = 1; k < AW; k++) begin : g_stage
            assign shifted[k] = r_q[k-1][k-1] ? (word_q[k-1] >> (2**(k-1)))
                                              : word_q[k-1];
        end
    endgenerate

    // Global enable: the whole pipe moves unless the output is held.
    assign adv          = !out_vld_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        for (int k = 0; k < AW; k++) begin
            word_d[k] = word_q[k];
            r_d[k]    = r_q[k];
            tag_d[k]  = tag_q[k];
            err_d[k]  = err_q[k];
            vld_d[k]  = vld_q[k];
        end
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        out_err_d  = out_err_q;
        out_vld_d  = out_vld_q;

        if (adv) begin
            word_d[0] = {dec_hi, dec_lo};
            r_d[0]    = dec_r;
            tag_d[0]  = bus.in_tag;
            err_d[0]  = dec_err;
            vld_d[0]  = bus.in_valid;
            for (int k = 1; k < AW; k++) begin
                word_d[k] = shifted[k];
                r_d[k]    = r_q[k-1];
                tag_d[k]  = tag_q[k-1];
                err_d[k]  = err_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
            // Last step shifts by W, i.e. selects the upper or lower half.
            out_data_d = r_q[AW-1][AW-1] ? word_q[AW-1][2*W-1:W]
                                         : word_q[AW-1][W-1:0];
            out_tag_d  = tag_q[AW-1];
            out_err_d  = err_q[AW-1];
            out_vld_d  = vld_q[AW-1];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < AW; k++) begin
                word_q[k] <= '0;
                r_q[k]    <= '0;
                tag_q[k]  <= '0;
                err_q[k]  <= 1'b0;
                vld_q[k]  <= 1'b0;
            end
            out_data_q <= '0;
            out_tag_q  <= '0;
            out_err_q  <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            for (int k = 0; k < AW; k++) begin
                word_q[k] <= word_d[k];
                r_q[k]    <= r_d[k];
                tag_q[k]  <= tag_d[k];
                err_q[k]  <= err_d[k];
                vld_q[k]  <= vld_d[k];
            end
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
            out_err_q  <= out_err_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shift_rotate.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_shift_rotate
// Description : Scoreboard bench for pipelined_shift_rotate (W=8, TW=5).
//               Expected results come from a behavioural shift model and are
//               queued on input handshake, popped on output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shift_rotate;
    localparam int W  = 8;
    localparam int TW = 5;

    logic clk;
    logic nrst;

    pipelined_shift_rotate_if #(.W(W), .TW(TW)) bus ();

    pipelined_shift_rotate #(.W(W), .TW(TW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    d;
        logic [TW-1:0] t;
        logic          e;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    bit   rnd     = 0;
    bit   accepted;
    bit   stall_prev = 0;
    logic [7:0]    prev_d;
    logic [TW-1:0] prev_t;
    logic          prev_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: returns {err, data}
    function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [3:0] n);
        logic [15:0] t;
        int          s;
        int          k;
        k = int'(n) % 8;
        t = '0;
        case (op)
            3'd0: begin t = {8'h00, a} << n; return {1'b0, t[7:0]}; end
            3'd1: begin t = {8'h00, a} >> n; return {1'b0, t[7:0]}; end
            3'd2: begin s = int'($signed(a)); s = s >>> n; return {1'b0, s[7:0]}; end
            3'd3: begin t = {a, a} << k;     return {1'b0, t[15:8]}; end
            3'd4: begin t = {a, a} >> k;     return {1'b0, t[7:0]}; end
            3'd5: begin t = {a, b} >> n;     return {1'b0, t[7:0]}; end
            default: return 9'h100;
        endcase
    endfunction

    // One cycle: check at negedge+1, record handshakes, advance to next negedge.
    task automatic tick();
        exp_t e;
        logic [8:0] m;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
        if (stall_prev) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_data",  {24'd0, bus.out_data}, {24'd0, prev_d});
            chk("stall_tag",   {27'd0, bus.out_tag},  {27'd0, prev_t});
            chk("stall_err",   {31'd0, bus.out_err},  {31'd0, prev_e});
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data", {24'd0, bus.out_data}, {24'd0, e.d});
                chk("tag",  {27'd0, bus.out_tag},  {27'd0, e.t});
                chk("err",  {31'd0, bus.out_err},  {31'd0, e.e});
                if (e.lat) chk("latency", cyc - e.acc, 32'd5);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            m     = model(bus.in_op, bus.in_a, bus.in_b, bus.in_n);
            e.d   = m[7:0];
            e.e   = m[8];
            e.t   = bus.in_tag;
            e.acc = cyc;
            e.lat = !rnd;
            sb.push_back(e);
            accepted = 1;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_d = bus.out_data;
        prev_t = bus.out_tag;
        prev_e = bus.out_err;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] n, input logic [TW-1:0] tag);
        int budget = 100;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_n     = n;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        accepted     = 0;
        while (!accepted && budget > 0) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            budget--;
        end
        if (!accepted) chk("accept_timeout", {31'd0, accepted}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 200;
        bus.in_valid = 1'b0;
        while (sb.size() > 0 && budget > 0) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            budget--;
        end
        chk("drain_timeout", sb.size(), 32'd0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_n      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        nrst          = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, bus.out_data},  32'd0);
        chk("rst_out_tag",   {27'd0, bus.out_tag},   32'd0);
        chk("rst_out_err",   {31'd0, bus.out_err},   32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        nrst = 1'b1;
        @(negedge clk);

        // Directed ops, out_ready held high: each must take exactly 5 cycles
        issue(3'd0, 8'h81, 8'h00, 4'd1,  5'd1);   // SLL  -> 02
        issue(3'd1, 8'h81, 8'h00, 4'd9,  5'd2);   // SRL  -> 00
        issue(3'd2, 8'h90, 8'h00, 4'd2,  5'd3);   // SRA  -> E4
        issue(3'd2, 8'h90, 8'h00, 4'd9,  5'd4);   // SRA  -> FF
        issue(3'd2, 8'h70, 8'h00, 4'd15, 5'd5);   // SRA  -> 00
        issue(3'd3, 8'h81, 8'h00, 4'd1,  5'd6);   // ROL  -> 03
        issue(3'd4, 8'h81, 8'h00, 4'd9,  5'd7);   // ROR  -> C0
        issue(3'd3, 8'h5A, 8'h00, 4'd8,  5'd8);   // ROL  -> 5A
        issue(3'd5, 8'hAB, 8'hCD, 4'd4,  5'd9);   // FUN  -> BC
        issue(3'd5, 8'hAB, 8'hCD, 4'd8,  5'd10);  // FUN  -> AB
        issue(3'd5, 8'hAB, 8'hCD, 4'd12, 5'd11);  // FUN  -> 0A
        issue(3'd5, 8'hAB, 8'hCD, 4'd0,  5'd12);  // FUN  -> CD
        issue(3'd6, 8'hFF, 8'hFF, 4'd3,  5'd13);  // reserved -> 00, err
        issue(3'd0, 8'hFF, 8'h00, 4'd0,  5'd14);  // SLL n=0 -> FF
        issue(3'd0, 8'hFF, 8'h00, 4'd8,  5'd15);  // SLL n=W -> 00
        drain();

        // Backpressure stream, tags 0..19 with random out_ready
        rnd = 1;
        for (int i = 0; i < 20; i++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  4'($urandom_range(0, 15)), 5'(i));
        end
        drain();
        rnd = 0;
        bus.out_ready = 1'b1;

        // Reset with three ops in flight
        issue(3'd1, 8'hF0, 8'h00, 4'd4, 5'd20);
        issue(3'd3, 8'h12, 8'h00, 4'd4, 5'd21);
        issue(3'd5, 8'h34, 8'h56, 4'd8, 5'd22);
        nrst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data",  {24'd0, bus.out_data},  32'd0);
        chk("mid_rst_tag",   {27'd0, bus.out_tag},   32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready},  32'd1);
        #2;
        nrst = 1'b1;
        sb.delete();
        stall_prev = 0;
        repeat (8) tick();                        // any output here is stale
        issue(3'd4, 8'h01, 8'h00, 4'd1, 5'd23);   // ROR -> 80
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/pipelined_shift_rotate.md
# pipelined_shift_rotate

Parametrised, pipelined shift/rotate/funnel unit with valid/ready handshakes on input and output. It generalises the team's 8-bit combinational funnel shifter and left/right shifter-rotator to any power-of-two width, and adds registered stages, backpressure and a sideband tag. Any mode can be selected per transaction. It sits between an operand source (register file read or test sequencer) and a result sink, and accepts one operation per cycle when the sink is ready.

## Interface
Parameters:
- `W`, 8: data width; power of two, ≥ 2.
- `TW`, 4: tag width, ≥ 1.
- Derived `AW` = $clog2(W)+1: shift-amount width.
- Derived `L` = $clog2(W)+2: latency in cycles.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted this cycle if `in_valid` is also high.
- `in_op`  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101 FUNNEL, 110/111 reserved.
- `in_a`  in  W  primary operand; upper word for FUNNEL.
- `in_b`  in  W  lower word for FUNNEL; ignored otherwise.
- `in_n`  in  AW  shift amount, 0..2W-1.
- `in_tag`  in  TW  sideband, returned unchanged with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  sink accepts the result.
- `out_data`  out  W  result.
- `out_tag`  out  TW  tag of the result.
- `out_err`  out  1  result came from a reserved op.

## Operation
- Internally every op becomes a right funnel extract: result = ({hi,lo} >> r)[W-1:0], where r is a value in 0..2W-1 and zeros fill from above.
- Stage 0 (decode, registered) computes hi, lo and r:
  - SLL: if n<W, then hi=a, lo=0, r=W-n. If n≥W, then hi=lo=0, r=0, so the result is 0.
  - SRL: hi=0, lo=a, r=n. If n≥W the result is 0.
  - SRA: hi={W{a[W-1]}}, lo=a, r=min(n,W). If n≥W the result is all sign bits.
  - ROR: hi=lo=a, r=n mod W.
  - ROL: hi=lo=a, r=(W-(n mod W)) mod W.
  - FUNNEL: hi=a, lo=b, r=n. n=W returns a; n>W returns a>>(n-W).
  - Reserved ops: hi=lo=0, r=0, and the err flag is set.
- Stages 1..AW: stage k shifts the 2W-bit word right by 2^(k-1) when r[k-1]=1. Each stage is registered.
- Tag, err and a valid bit travel with each entry through all L stages.
- Flow control is a global enable: adv = !out_valid || out_ready.
  - When adv=1, all stages shift forward one position and stage 0 captures the input (valid = in_valid).
  - When adv=0, every stage holds.
  - in_ready = adv. It is combinational from `out_ready` and `out_valid`, and does not depend on `in_valid`.
- Bubbles are not collapsed. An empty slot still costs one cycle of latency.

## Timing
- Reset (`nrst` low, asynchronous): every stage valid bit is 0, and `out_valid`=0, `out_data`=0, `out_tag`=0, `out_err`=0.
  - `in_ready` = 1 once reset is asserted, because out_valid=0.
  - Reset mid-operation discards all in-flight entries. No result for them ever appears.
- Latency: an input accepted at edge t appears on the outputs after edge t+L-1, which is L cycles of in_valid→out_valid with no stalls. For W=8, L=5.
- Throughput: 1 result per cycle while `out_ready`=1.
- Stall rule: while out_valid=1 and out_ready=0, `out_data`, `out_tag` and `out_err` stay stable, in_ready=0, and no input is taken.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the output drains and the input is captured on that one edge.
- `out_valid` may fall only after a handshake or a reset.
- Ordering is strict FIFO. No result is lost or duplicated.

## Test plan
- Reset and latency (W=8): release `nrst`, hold out_ready=1, send SLL a=0x81 n=1 → out_data=0x02 exactly 5 cycles later. Then SRL a=0x81 n=9 → 0x00.
- Arithmetic bounds: SRA a=0x90 n=2 → 0xE4; SRA a=0x90 n=9 → 0xFF; SRA a=0x70 n=15 → 0x00.
- Rotates: ROL a=0x81 n=1 → 0x03; ROR a=0x81 n=9 → 0xC0; ROL a=0x5A n=8 → 0x5A.
- Funnel: a=0xAB b=0xCD with n=4 → 0xBC, n=8 → 0xAB, n=12 → 0x0A, n=0 → 0xCD. Then op=110 → data 0x00 with out_err=1.
- Backpressure: stream 20 ops with tags 0..19 while toggling out_ready randomly.
  - Outputs must stay stable across stalls.
  - Tags must arrive in order 0..19 with none missing.
  - in_ready must equal !out_valid||out_ready on every cycle.
- Reset mid-flight: with 3 ops in the pipe, pulse `nrst` low for half a cycle between edges. Outputs are 0 immediately and no stale result appears afterwards. The next op completes after 5 cycles.
